vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator running in the `pixel_clk` domain. It counts pixel and line positions over a configurable total raster, then produces sync, active-video and start-of-line/frame strobes. Sync and strobe outputs are delayed by a programmable pipeline so they stay aligned with a downstream pixel generator of known latency. It sits between the pixel-clock source and the pixel generator of the elevator display path, and exposes the raw X/Y coordinates to the pixel generator.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `HSYNC_POL`, 0: hsync asserted level; 0 = active-low.
- `VSYNC_POL`, 0: vsync asserted level; 0 = active-low.
- `CNT_W`, 10: counter width. Must satisfy 2^CNT_W ≥ max(H_TOTAL, V_TOTAL).
- `PIPE_DLY`, 1: output delay in cycles, range 1..8.

Ports (clock and reset first):
- `pixel_clk`, in, 1: pixel clock.
- `reset`, in, 1: asynchronous, active-high.
- `run`, in, 1: when high, the raster advances; when low, counters are held at 0 and outputs are inactive.
- `x`, out, CNT_W: horizontal counter, h_cnt.
- `y`, out, CNT_W: vertical counter, v_cnt.
- `hsync`, out, 1: horizontal sync, polarity set by HSYNC_POL.
- `vsync`, out, 1: vertical sync, polarity set by VSYNC_POL.
- `active`, out, 1: high inside the visible region.
- `line_start`, out, 1: one-cycle pulse at h_cnt = 0.
- `frame_start`, out, 1: one-cycle pulse at h_cnt = 0 and v_cnt = 0.
- `frame_count`, out, 16: number of completed frames.

## Operation
- Derived totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800 with defaults); V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (525 with defaults).
- Horizontal counter h_cnt: counts 0..H_TOTAL-1, then wraps to 0.
- Vertical counter v_cnt: increments only on the cycle h_cnt wraps; wraps to 0 after V_TOTAL-1.
- Decoded signals, computed from the current counter values:
  - hs_raw = H_ACTIVE+H_FP ≤ h_cnt ≤ H_ACTIVE+H_FP+H_SYNC-1.
  - vs_raw = V_ACTIVE+V_FP ≤ v_cnt ≤ V_ACTIVE+V_FP+V_SYNC-1, held for whole lines.
  - act_raw = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - ls_raw = h_cnt == 0.
  - fs_raw = h_cnt == 0 and v_cnt == 0.
- The decoded signals pass through a PIPE_DLY-stage shift register before driving the outputs.
- Output sync level: hsync = hs_delayed ? HSYNC_POL : !HSYNC_POL. vsync uses the same rule with VSYNC_POL.
- `x` and `y` are driven straight from the counter registers, with no extra delay.
- When `run` is low:
  - h_cnt and v_cnt load 0 on the next edge.
  - A zero value (inactive) is shifted into the pipeline, so outputs go inactive within PIPE_DLY cycles.
  - frame_count holds its value.
- When `run` rises, the first counting cycle is h_cnt = v_cnt = 0. fs_raw is asserted on that cycle.
- frame_count increments when v_cnt wraps from V_TOTAL-1 to 0. It wraps modulo 2^16.
- All arithmetic is unsigned and CNT_W wide. Parameter legality is checked at elaboration; an illegal value is a fatal error.

## Timing
- Reset value of every output:
  - x = 0, y = 0.
  - hsync = !HSYNC_POL, vsync = !VSYNC_POL.
  - active = 0, line_start = 0, frame_start = 0.
  - frame_count = 0.
  - All pipeline stages hold inactive values.
- Reset is asynchronous; reset asserted mid-frame forces every output to its reset value immediately.
- Latency: the sync/active/start output at cycle t reflects the counter state at cycle t-PIPE_DLY. x and y have zero latency.
- Frame period is H_TOTAL × V_TOTAL cycles; 420000 with defaults.
- line_start and frame_start are exactly one cycle wide.
- Simultaneous events: at h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, both counters wrap on the same edge and frame_count increments on that edge.
- `run` falling on the cycle of a frame wrap: the counters go to 0 and frame_count still increments.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN`:
  - Defined: the 16-bit frame counter is built as described above.
  - Undefined: the counter logic is removed and frame_count is tied to 16'h0000.
  - All other behaviour is unchanged in both cases.

## Test plan
- Defaults, run = 1 held: hsync is low for h_cnt 656..751, i.e. 96 cycles, with a period of 800 cycles.
- Defaults: vsync is low for lines 490..491 (1600 cycles); frame_start pulses occur every 420000 cycles.
- PIPE_DLY = 3: the first active = 1 after reset release appears 3 cycles after x = 0, y = 0 with run high. Rising edges of active are spaced 800 cycles apart; each active burst lasts 640 cycles.
- HSYNC_POL = 1, VSYNC_POL = 1: sync outputs idle at 0 after reset and pulse high in the same windows as the default test.
- Drop run at x = 300, y = 200: the next cycle shows x = 0, y = 0. Outputs are inactive within PIPE_DLY cycles. On re-raise, frame_start appears PIPE_DLY cycles later.
- Macro defined: frame_count reads 2 after 840000 cycles; asserting reset mid-line clears it to 0 asynchronously. Macro undefined: frame_count stays 0 throughout.

Source files
------------

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator for the pixel_clk domain.
//   A horizontal/vertical counter pair walks the full raster; the decoded
//   sync, active and start-of-line/frame flags are delayed by PIPE_DLY
//   register stages so they line up with a downstream pixel generator.
//   x/y are the raw counters with no delay.
//
//   Optional feature macro: VGA_TIMING_FRAME_CNT_EN
//     defined   -> 16-bit completed-frame counter on frame_count
//     undefined -> frame_count tied to 16'h0000
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10,
  parameter int PIPE_DLY  = 1
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic             run,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_count
);

  // ---------------------------------------------------------------------------
  // Derived raster geometry
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter legality
  // ---------------------------------------------------------------------------
  if (CNT_W < 1 || CNT_W > 32) begin : g_err_cnt_w
    $fatal(1, "vga_timing_gen: CNT_W must be in 1..32");
  end
  if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_err_pipe_dly
    $fatal(1, "vga_timing_gen: PIPE_DLY must be in 1..8");
  end
  if (H_ACTIVE < 1 || H_SYNC < 1 || H_FP < 0 || H_BP < 0) begin : g_err_h_geom
    $fatal(1, "vga_timing_gen: illegal horizontal timing parameters");
  end
  if (V_ACTIVE < 1 || V_SYNC < 1 || V_FP < 0 || V_BP < 0) begin : g_err_v_geom
    $fatal(1, "vga_timing_gen: illegal vertical timing parameters");
  end
  if (longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
      longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_err_cnt_range
    $fatal(1, "vga_timing_gen: CNT_W too narrow for the raster totals");
  end

  // Compare constants, all CNT_W wide so every comparison is unsigned.
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // One pipeline stage worth of decoded raster flags (all active-high).
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic ls;
    logic fs;
  } flags_t;

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_frame_wrap;
  flags_t           w_raw;
  flags_t           w_out;
  flags_t           r_pipe [PIPE_DLY];

  assign w_h_last     = (r_h_cnt == H_LAST);
  assign w_v_last     = (r_v_cnt == V_LAST);
  // End-of-frame position; frame_count advances on this edge even if run
  // is dropping at the same moment.
  assign w_frame_wrap = w_h_last && w_v_last;

  // Raster counters: advance while run is high, park at 0 while it is low.
  always_ff @(posedge pixel_clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Decode the current counter position; forced inactive while stopped.
  always_comb begin
    // NOTE: default every field first so no path leaves a flag unassigned,
    // which would otherwise infer a latch.
    w_raw = '0;
    if (run) begin
      w_raw.hs  = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
      w_raw.vs  = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
      w_raw.act = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
      w_raw.ls  = (r_h_cnt == '0);
      w_raw.fs  = (r_h_cnt == '0) && (r_v_cnt == '0);
    end
  end

  // Alignment delay line: PIPE_DLY stages of decoded flags.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      // NOTE: every stage is reset (not just the last) because any stale
      // stage would emerge on the outputs after reset release.
      for (int i = 0; i < PIPE_DLY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_raw;
      for (int i = 1; i < PIPE_DLY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign w_out       = r_pipe[PIPE_DLY-1];
  assign hsync       = w_out.hs ? HSYNC_POL : !HSYNC_POL;
  assign vsync       = w_out.vs ? VSYNC_POL : !VSYNC_POL;
  assign active      = w_out.act;
  assign line_start  = w_out.ls;
  assign frame_start = w_out.fs;
  assign x           = r_h_cnt;
  assign y           = r_v_cnt;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Completed-frame counter, wraps modulo 2^16.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_count = r_frame_cnt;
`else
  logic w_unused_wrap;
  assign w_unused_wrap = w_frame_wrap;
  assign frame_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Scoreboard bench for vga_timing_gen on a reduced raster (32 x 15).
//   The stimulus process drives run, advances a linear-position reference
//   model and queues the expected outputs; a monitor pops one entry per
//   clock and compares. Honours VGA_TIMING_FRAME_CNT_EN for frame_count.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 32
  localparam int VT = VA + VF + VS + VB;   // 15
  localparam int FT = HT * VT;             // 480 cycles per frame
  localparam int CW = 6;
  localparam int PD = 3;
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;

  logic          pixel_clk = 1'b0;
  logic          reset;
  logic          run;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic          line_start;
  logic          frame_start;
  logic [15:0]   frame_count;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .CNT_W(CW), .PIPE_DLY(PD)
  ) dut (
    .pixel_clk  (pixel_clk),
    .reset      (reset),
    .run        (run),
    .x          (x),
    .y          (y),
    .hsync      (hsync),
    .vsync      (vsync),
    .active     (active),
    .line_start (line_start),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  typedef struct packed {
    bit hs;
    bit vs;
    bit act;
    bit ls;
    bit fs;
  } raw_t;

  typedef struct {
    int   x;
    int   y;
    raw_t f;
    int   fc;
  } exp_t;

  exp_t sb_q[$];
  raw_t hist[$];
  int   pos;        // linear pixel index within the frame = y*HT + x
  int   fc;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // Raster flags for a linear position, straight from the timing rules.
  function automatic raw_t decode(input int p);
    raw_t d;
    int h, v;
    h     = p % HT;
    v     = p / HT;
    d.hs  = (h >= HA + HF) && (h < HA + HF + HS);
    d.vs  = (v >= VA + VF) && (v < VA + VF + VS);
    d.act = (h < HA) && (v < VA);
    d.ls  = (h == 0);
    d.fs  = (p == 0);
    return d;
  endfunction

  task automatic model_reset();
    pos = 0;
    fc  = 0;
    hist.delete();
    for (int i = 0; i < PD - 1; i++) hist.push_back('0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".x"},           32'(x),           32'd0);
    check({tag, ".y"},           32'(y),           32'd0);
    check({tag, ".hsync"},       32'(hsync),       32'(!HP));
    check({tag, ".vsync"},       32'(vsync),       32'(!VP));
    check({tag, ".active"},      32'(active),      32'd0);
    check({tag, ".line_start"},  32'(line_start),  32'd0);
    check({tag, ".frame_start"}, 32'(frame_start), 32'd0);
    check({tag, ".frame_count"}, 32'(frame_count), 32'd0);
  endtask

  // One clock of stimulus: drive run, predict the post-edge outputs, queue them.
  task automatic step(input bit r);
    raw_t raw;
    raw_t dly;
    exp_t e;
    run = r;
    raw = r ? decode(pos) : raw_t'('0);
    hist.push_back(raw);
    dly = hist.pop_front();
`ifdef VGA_TIMING_FRAME_CNT_EN
    if (pos == FT - 1) fc = (fc + 1) % 65536;
`endif
    pos  = r ? (pos + 1) % FT : 0;
    e.x  = pos % HT;
    e.y  = pos / HT;
    e.f  = dly;
    e.fc = fc;
    sb_q.push_back(e);
    @(negedge pixel_clk);
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (pos != target && guard < 2 * FT) begin
      step(1'b1);
      guard++;
    end
    if (pos != target) check("run_to_reached", 32'(pos), 32'(target));
  endtask

  // Monitor: one expectation per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge pixel_clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("x",           32'(x),           32'(e.x));
        check("y",           32'(y),           32'(e.y));
        check("hsync",       32'(hsync),       32'(e.f.hs ? HP : !HP));
        check("vsync",       32'(vsync),       32'(e.f.vs ? VP : !VP));
        check("active",      32'(active),      32'(e.f.act));
        check("line_start",  32'(line_start),  32'(e.f.ls));
        check("frame_start", 32'(frame_start), 32'(e.f.fs));
        check("frame_count", 32'(frame_count), 32'(e.fc));
      end
    end
  end

  // Stimulus
  initial begin
    int guard;
    reset = 1'b1;
    run   = 1'b0;
    model_reset();
    #2 check_reset_vals("por");
    @(negedge pixel_clk);
    reset = 1'b0;

    // Idle a few cycles with run low, then two full frames with run held.
    repeat (4) step(1'b0);
    repeat (2 * FT + 37) step(1'b1);

    // Drop run mid-frame, then restart from 0.
    run_to(6 * HT + 10);
    repeat (PD + 2) step(1'b0);
    repeat (FT) step(1'b1);

    // Drop run exactly on the frame-wrap cycle.
    run_to(FT - 1);
    repeat (5) step(1'b0);
    repeat (50) step(1'b1);

    // Frequent random run toggling.
    repeat (1500) step($urandom_range(0, 15) != 0);

    // Long random runs reaching the sync lines and frame wraps.
    repeat (3000) step($urandom_range(0, 399) != 0);

    // Asynchronous reset in the middle of a line, away from the clock edge.
    run_to(3 * HT + 7);
    #2;
    reset = 1'b1;
    run   = 1'b0;
    #1 check_reset_vals("async");
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    reset = 1'b0;
    model_reset();
    repeat (FT + 20) step(1'b1);

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(posedge pixel_clk);
      #2;
      guard++;
    end
    if (sb_q.size() > 0) check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
